// File: rtl/uart_cmd_parser_if.sv
// Byte-stream and decoded-command bundle between uart_rx and uart_cmd_parser.
// master drives the received bytes; slave is the parser.
interface uart_cmd_parser_if #(
  parameter int VALUE_W = 32
);
  logic [7:0]         rx_data;
  logic               rx_vld;
  logic [7:0]         cmd_key;
  logic [VALUE_W-1:0] cmd_value;
  logic               cmd_vld;
  logic               cmd_err;
  logic [1:0]         err_code;
  logic               busy;

  modport master (
    output rx_data, rx_vld,
    input  cmd_key, cmd_value, cmd_vld, cmd_err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_vld,
    output cmd_key, cmd_value, cmd_vld, cmd_err, err_code, busy
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Decodes "&&K:DDDD&&" frames from a UART byte stream into a key/value strobe,
// flagging malformed, overflowing or stalled frames with a cause code.
module uart_cmd_parser #(
  parameter int VALUE_W        = 32,
  parameter int MAX_DIGITS     = 10,
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  uart_cmd_parser_if.slave bus
);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int ACC_W = VALUE_W + 4;

  typedef enum logic [2:0] {S_IDLE, S_SOF, S_KEY, S_COLON, S_DIGIT, S_EOF} state_t;
  typedef enum logic [1:0] {E_NONE, E_BAD_CHAR, E_OVERFLOW, E_TIMEOUT} err_t;

  state_t             state, state_d;
  logic [7:0]         key, key_d;
  logic [VALUE_W-1:0] acc, acc_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic [7:0]         out_key, out_key_d;
  logic [VALUE_W-1:0] out_value, out_value_d;
  logic               out_vld, out_vld_d;
  logic               out_err, out_err_d;
  err_t               code, code_d;

  logic             is_digit;
  logic [ACC_W-1:0] acc_wide, acc_next;
  logic             abort, commit;
  err_t             cause;

  assign is_digit = bus.rx_data inside {[8'h30:8'h39]};
  assign acc_wide = ACC_W'(acc);
  // acc*10 + digit; the four spare bits make the overflow test exact.
  assign acc_next = (acc_wide << 3) + (acc_wide << 1) + ACC_W'(bus.rx_data[3:0]);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state;
    key_d       = key;
    acc_d       = acc;
    cnt_d       = cnt;
    timer_d     = (state == S_IDLE || bus.rx_vld) ? '0 : timer + 1'b1;
    out_key_d   = out_key;
    out_value_d = out_value;
    out_vld_d   = 1'b0;
    out_err_d   = 1'b0;
    code_d      = code;
    abort       = 1'b0;
    commit      = 1'b0;
    cause       = E_NONE;

    if (bus.rx_vld) begin
      unique case (state)
        S_IDLE: if (bus.rx_data == "&") state_d = S_SOF;
        S_SOF:  state_d = (bus.rx_data == "&") ? S_KEY : S_IDLE;
        S_KEY: begin
          if (bus.rx_data inside {[8'h41:8'h5A]}) begin
            key_d   = bus.rx_data;
            state_d = S_COLON;
          end else if (bus.rx_data != "&") begin
            abort = 1'b1;
            cause = E_BAD_CHAR;
          end
        end
        S_COLON: begin
          if (bus.rx_data == ":") begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_DIGIT;
          end else begin
            abort = 1'b1;
            cause = E_BAD_CHAR;
          end
        end
        S_DIGIT: begin
          if (is_digit) begin
            if (cnt == CNT_W'(MAX_DIGITS) || |acc_next[ACC_W-1:VALUE_W]) begin
              abort = 1'b1;
              cause = E_OVERFLOW;
            end else begin
              acc_d = acc_next[VALUE_W-1:0];
              cnt_d = cnt + 1'b1;
            end
          end else if (bus.rx_data == "&" && cnt != '0) begin
            state_d = S_EOF;
          end else begin
            abort = 1'b1;
            cause = E_BAD_CHAR;
          end
        end
        S_EOF: begin
          if (bus.rx_data == "&") commit = 1'b1;
          else begin
            abort = 1'b1;
            cause = E_BAD_CHAR;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state != S_IDLE && timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
      abort = 1'b1;
      cause = E_TIMEOUT;
    end

    if (abort) begin
      out_err_d = 1'b1;
      code_d    = cause;
      state_d   = S_IDLE;
      timer_d   = '0;
    end else if (commit) begin
      out_vld_d   = 1'b1;
      code_d      = E_NONE;
      out_key_d   = key;
      out_value_d = acc;
      state_d     = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      key       <= '0;
      acc       <= '0;
      cnt       <= '0;
      timer     <= '0;
      out_key   <= '0;
      out_value <= '0;
      out_vld   <= 1'b0;
      out_err   <= 1'b0;
      code      <= E_NONE;
    end else begin
      state     <= state_d;
      key       <= key_d;
      acc       <= acc_d;
      cnt       <= cnt_d;
      timer     <= timer_d;
      out_key   <= out_key_d;
      out_value <= out_value_d;
      out_vld   <= out_vld_d;
      out_err   <= out_err_d;
      code      <= code_d;
    end
  end

  assign bus.cmd_key   = out_key;
  assign bus.cmd_value = out_value;
  assign bus.cmd_vld   = out_vld;
  assign bus.cmd_err   = out_err;
  assign bus.err_code  = code;
  assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames plus random traffic,
// compared cycle by cycle against a behavioural frame model.
`timescale 1ns/1ps
module tb_uart_cmd_parser;
  localparam int VALUE_W = 32;
  localparam int MAX_DIG = 10;
  localparam int TO      = 100;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_cmd_parser_if #(.VALUE_W(VALUE_W)) bus ();

  uart_cmd_parser #(
    .VALUE_W(VALUE_W), .MAX_DIGITS(MAX_DIG), .TIMEOUT_CYCLES(TO)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .bus(bus)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: frame phase 0 idle, 1 after '&', 2 key, 3 colon, 4 digits, 5 closing.
  int          m_ph, m_cnt, m_idle;
  longint      m_acc;
  logic [7:0]  m_key;
  logic        e_vld, e_err, e_busy;
  logic [1:0]  e_code;
  logic [7:0]  e_key;
  logic [31:0] e_val;

  // Per-run tallies observed by the driver.
  int    n_vld, n_err, n_both, n_diff;
  string first_diff;

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_idle = 0; m_acc = 0; m_key = 0;
    e_vld = 0; e_err = 0; e_busy = 0; e_code = 0; e_key = 0; e_val = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    int ab;
    ab = 0;
    e_vld = 0;
    e_err = 0;
    if (v) begin
      m_idle = 0;
      case (m_ph)
        0: if (b == "&") m_ph = 1;
        1: m_ph = (b == "&") ? 2 : 0;
        2: if (b >= "A" && b <= "Z") begin m_key = b; m_ph = 3; end
           else if (b != "&") ab = 1;
        3: if (b == ":") begin m_acc = 0; m_cnt = 0; m_ph = 4; end
           else ab = 1;
        4: if (b >= "0" && b <= "9") begin
             if (m_cnt == MAX_DIG) ab = 2;
             else if (m_acc * 10 + (b - 48) > 64'hFFFF_FFFF) ab = 2;
             else begin m_acc = m_acc * 10 + (b - 48); m_cnt++; end
           end else if (b == "&" && m_cnt >= 1) m_ph = 5;
           else ab = 1;
        default: if (b == "&") begin
                   e_vld = 1; e_code = 0; e_key = m_key; e_val = m_acc[31:0]; m_ph = 0;
                 end else ab = 1;
      endcase
    end else if (m_ph != 0) begin
      m_idle++;
      if (m_idle == TO) ab = 3;
    end
    if (ab != 0) begin
      e_err = 1; e_code = 2'(ab); m_ph = 0; m_idle = 0;
    end
    e_busy = (m_ph != 0);
  endtask

  // One clock: drive inputs, let the edge pass, advance the model, sample 1 ns later.
  task automatic drive(input logic v, input logic [7:0] b);
    bus.rx_vld  = v;
    bus.rx_data = b;
    @(posedge clk);
    model_step(v, b);
    #1;
    bus.rx_vld = 1'b0;
    if (bus.cmd_vld) n_vld++;
    if (bus.cmd_err) n_err++;
    if (bus.cmd_vld && bus.cmd_err) n_both++;
    if ({bus.cmd_vld, bus.cmd_err, bus.err_code, bus.busy, bus.cmd_key, bus.cmd_value}
        !== {e_vld, e_err, e_code, e_busy, e_key, e_val}) begin
      if (n_diff == 0)
        first_diff = $sformatf("byte %02h: vld/err/code/busy/key/val got %b%b %0d %b %02h %0d want %b%b %0d %b %02h %0d",
                               b, bus.cmd_vld, bus.cmd_err, bus.err_code, bus.busy, bus.cmd_key,
                               bus.cmd_value, e_vld, e_err, e_code, e_busy, e_key, e_val);
      n_diff++;
    end
  endtask

  task automatic send_str(input string s, input int gap_max);
    for (int i = 0; i < s.len(); i++) begin
      drive(1'b1, s[i]);
      repeat ($urandom_range(0, gap_max)) drive(1'b0, 8'h00);
    end
  endtask

  task automatic clear_tallies();
    n_vld = 0; n_err = 0; n_both = 0; n_diff = 0; first_diff = "";
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.rx_vld = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.cmd_vld, bus.cmd_err, bus.err_code, bus.busy, bus.cmd_key, bus.cmd_value} !== '0)
      $display("FAIL reset_outputs: got vld=%b err=%b code=%0d busy=%b key=%02h val=%0d, want all 0",
               bus.cmd_vld, bus.cmd_err, bus.err_code, bus.busy, bus.cmd_key, bus.cmd_value);
    else passed++;
  endtask

  task automatic test_good_frame();
    do_reset(); clear_tallies();
    send_str("&&F:12345&&", 0);
    total++;
    if ({bus.cmd_vld, bus.cmd_key, bus.cmd_value, bus.err_code, bus.busy} !== {1'b1, 8'h46, 32'd12345, 2'd0, 1'b0})
      $display("FAIL good_frame: got vld=%b key=%02h val=%0d code=%0d busy=%b, want 1 46 12345 0 0",
               bus.cmd_vld, bus.cmd_key, bus.cmd_value, bus.err_code, bus.busy);
    else passed++;
    drive(1'b0, 8'h00);
    total++;
    if (bus.cmd_vld !== 1'b0 || n_vld !== 1)
      $display("FAIL good_frame_pulse: got vld=%b pulses=%0d, want 0 1", bus.cmd_vld, n_vld);
    else passed++;
    total++;
    if (n_diff !== 0) $display("FAIL good_frame_trace: %0d diffs, first %s, want 0", n_diff, first_diff);
    else passed++;
  endtask

  task automatic test_boundary();
    do_reset(); clear_tallies();
    send_str("&&A:4294967295&&", 0);
    total++;
    if (bus.cmd_value !== 32'hFFFF_FFFF || n_vld !== 1)
      $display("FAIL max_value: got val=%h pulses=%0d, want ffffffff 1", bus.cmd_value, n_vld);
    else passed++;
    send_str("&&A:4294967296&&", 0);
    send_str("&&A:00000000001&&", 0);
    total++;
    if (n_err !== 2 || bus.err_code !== 2'd2 || bus.cmd_value !== 32'hFFFF_FFFF)
      $display("FAIL overflow: got errs=%0d code=%0d val=%h, want 2 2 ffffffff", n_err, bus.err_code, bus.cmd_value);
    else passed++;
    total++;
    if (n_diff !== 0) $display("FAIL boundary_trace: %0d diffs, first %s, want 0", n_diff, first_diff);
    else passed++;
  endtask

  task automatic test_malformed();
    do_reset(); clear_tallies();
    send_str("&&f:1&&", 0);
    send_str("&&B1&&", 0);
    send_str("&&C:&&", 0);
    send_str("&&D:12&x", 0);
    total++;
    if (n_err !== 4 || n_vld !== 0 || bus.err_code !== 2'd1)
      $display("FAIL malformed: got errs=%0d vlds=%0d code=%0d, want 4 0 1", n_err, n_vld, bus.err_code);
    else passed++;
    total++;
    if (n_diff !== 0) $display("FAIL malformed_trace: %0d diffs, first %s, want 0", n_diff, first_diff);
    else passed++;
  endtask

  task automatic test_sync_noise();
    do_reset(); clear_tallies();
    send_str("x&y&&&&G:7&&", 0);
    total++;
    if (n_err !== 0 || n_vld !== 1 || bus.cmd_key !== "G" || bus.cmd_value !== 32'd7)
      $display("FAIL sync_noise: got errs=%0d vlds=%0d key=%02h val=%0d, want 0 1 47 7",
               n_err, n_vld, bus.cmd_key, bus.cmd_value);
    else passed++;
    total++;
    if (n_diff !== 0) $display("FAIL sync_trace: %0d diffs, first %s, want 0", n_diff, first_diff);
    else passed++;
  endtask

  task automatic test_timeout();
    int k;
    logic seen;
    do_reset(); clear_tallies();
    send_str("&&H:5", 0);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 2 * TO) begin
      drive(1'b0, 8'h00);
      k++;
      if (bus.cmd_err) seen = 1'b1;
    end
    total++;
    if (!seen || k !== TO || bus.err_code !== 2'd3)
      $display("FAIL timeout: got seen=%b after %0d idle cycles code=%0d, want 1 %0d 3", seen, k, bus.err_code, TO);
    else passed++;
    send_str("&&H:5&&", 0);
    total++;
    if (bus.cmd_vld !== 1'b1 || bus.cmd_value !== 32'd5 || bus.err_code !== 2'd0)
      $display("FAIL after_timeout: got vld=%b val=%0d code=%0d, want 1 5 0", bus.cmd_vld, bus.cmd_value, bus.err_code);
    else passed++;
    clear_tallies();
    send_str("&&H:5", 0);
    repeat (TO - 1) drive(1'b0, 8'h00);
    drive(1'b1, "&");
    repeat (TO - 1) drive(1'b0, 8'h00);
    drive(1'b1, "&");
    total++;
    if (n_err !== 0 || n_vld !== 1)
      $display("FAIL threshold_byte: got errs=%0d vlds=%0d, want 0 1", n_err, n_vld);
    else passed++;
    total++;
    if (n_diff !== 0) $display("FAIL timeout_trace: %0d diffs, first %s, want 0", n_diff, first_diff);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    do_reset(); clear_tallies();
    send_str("&&Q:42&&&&K:99", 0);
    do_reset();
    total++;
    if ({bus.cmd_vld, bus.cmd_err, bus.err_code, bus.busy, bus.cmd_key, bus.cmd_value} !== '0)
      $display("FAIL mid_reset_outputs: got key=%02h val=%0d code=%0d busy=%b, want all 0",
               bus.cmd_key, bus.cmd_value, bus.err_code, bus.busy);
    else passed++;
    clear_tallies();
    send_str("9&&", 0);
    total++;
    if (n_vld !== 0 || n_err !== 0)
      $display("FAIL mid_reset_tail: got vlds=%0d errs=%0d, want 0 0", n_vld, n_err);
    else passed++;
    send_str("&&K:1&&", 0);
    total++;
    if (bus.cmd_vld !== 1'b1 || bus.cmd_key !== "K" || bus.cmd_value !== 32'd1)
      $display("FAIL mid_reset_next: got vld=%b key=%02h val=%0d, want 1 4b 1", bus.cmd_vld, bus.cmd_key, bus.cmd_value);
    else passed++;
  endtask

  task automatic test_back_to_back();
    string s;
    longint v;
    int i;
    do_reset(); clear_tallies();
    for (int f = 0; f < 200; f++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom_range(0, 9999);
        1: v = longint'($urandom);
        2: v = 64'h1_0000_0000 + $urandom_range(0, 1000);
        default: v = 64'hFFFF_FFFF - $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 7) == 0)
        s = $sformatf("&&%c:%011d&&", 8'($urandom_range(65, 90)), v % 100);
      else
        s = $sformatf("&&%c:%0d&&", 8'($urandom_range(65, 90)), v);
      if ($urandom_range(0, 3) == 0) begin
        i = $urandom_range(1, s.len() - 2);
        s = $sformatf("%s%c%s", s.substr(0, i - 1), 8'($urandom_range(33, 126)), s.substr(i + 1, s.len() - 1));
      end
      send_str(s, (f < 100) ? 0 : 2);
    end
    total++;
    if (n_diff !== 0) $display("FAIL random_trace: %0d diffs, first %s, want 0", n_diff, first_diff);
    else passed++;
    total++;
    if (n_both !== 0 || n_vld == 0 || n_err == 0)
      $display("FAIL random_pulses: got both=%0d vlds=%0d errs=%0d, want 0 >0 >0", n_both, n_vld, n_err);
    else passed++;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.rx_vld  = 1'b0;
    bus.rx_data = 8'h00;
    model_reset();
    clear_tallies();
    @(posedge clk);
    #1;
    test_reset();
    test_good_frame();
    test_boundary();
    test_malformed();
    test_sync_noise();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command decoder that sits directly downstream of the UART receiver (`uart_rx`), consuming its `rx_data`/`rx_vld` byte stream. It recognises frames of the form `&&K:DDDD&&`, where K is one uppercase ASCII letter and DDDD is an unsigned decimal number. Each good frame produces a one-cycle `cmd_vld` with the key and binary value. Malformed, overflowing or stalled frames produce a one-cycle `cmd_err` with a cause code. Downstream control logic uses the output as a register-write strobe.

## Interface
- `VALUE_W`, 32: width of decoded value.
- `MAX_DIGITS`, 10: maximum decimal digits accepted, including leading zeros.
- `TIMEOUT_CYCLES`, 500_000: maximum idle cycles between bytes inside a frame (10 ms at 50 MHz).

Ports:
- `sys_clk` in 1: single clock; everything is synchronous to its rising edge.
- `sys_rst_n` in 1: reset, synchronous, active-low.
- `rx_data` in 8: received byte; valid only when `rx_vld`=1.
- `rx_vld` in 1: one-cycle strobe per byte; may be high on consecutive cycles.
- `cmd_key` out 8: ASCII key of the last good frame.
- `cmd_value` out VALUE_W: value of the last good frame.
- `cmd_vld` out 1: one-cycle pulse, good frame decoded.
- `cmd_err` out 1: one-cycle pulse, frame aborted.
- `err_code` out 2: cause of the last abort. 0 = none, 1 = BAD_CHAR, 2 = OVERFLOW, 3 = TIMEOUT.
- `busy` out 1: high whenever state ≠ S_IDLE.

## Operation
The FSM advances only on cycles with `rx_vld`=1, except for timeout.

- **S_IDLE:** `&` → S_SOF; any other byte is ignored.
- **S_SOF:** `&` → S_KEY; any other byte → S_IDLE silently, with no error.
- **S_KEY:**
  - `A`–`Z` → latch key, → S_COLON.
  - `&` → stay in S_KEY; extra sync characters are tolerated.
  - Any other byte → abort BAD_CHAR.
- **S_COLON:** `:` → S_DIGIT and clear the accumulator and digit count; otherwise abort BAD_CHAR.
- **S_DIGIT:**
  - `0`–`9`:
    - If digit count = MAX_DIGITS → abort OVERFLOW.
    - Otherwise acc_next = (acc<<3)+(acc<<1)+(byte−8'h30), computed at VALUE_W+4 bits.
    - If any bit above VALUE_W−1 is set → abort OVERFLOW.
    - Otherwise store acc_next and increment the digit count.
  - `&` with count ≥ 1 → S_EOF.
  - `&` with count = 0 → abort BAD_CHAR.
  - Any other byte → abort BAD_CHAR.
- **S_EOF:** `&` → commit, → S_IDLE; any other byte → abort BAD_CHAR.

**Commit:**
- `cmd_key` ← latched key; `cmd_value` ← acc[VALUE_W−1:0].
- `cmd_vld` pulses; `err_code` ← 0.

**Abort:**
- `cmd_err` pulses; `err_code` ← cause; FSM → S_IDLE.
- `cmd_key` and `cmd_value` keep their previous good values.
- The aborting byte is consumed. It is not re-examined as a start character, even if it is `&`.

**Timeout:**
- A counter clears on every `rx_vld` and while in S_IDLE. It increments on every other cycle.
- When it reaches TIMEOUT_CYCLES−1 with no `rx_vld` in that cycle → abort TIMEOUT.
- An `rx_vld` in the same cycle as the timeout threshold wins: the byte is processed and the counter clears.

## Timing
- **Reset values:** all outputs 0; FSM S_IDLE; accumulator, digit count and timeout counter 0. Reset asserted mid-frame → S_IDLE on the next edge, with no pulse emitted.
- **Latency:** `cmd_vld`/`cmd_err` are registered and go high exactly one cycle after the `rx_vld` cycle carrying the deciding byte, for exactly one cycle. `cmd_key`, `cmd_value` and `err_code` update in that same cycle and then hold.
- **Exclusivity:** `cmd_vld` and `cmd_err` are never high together.
- **Throughput:** back-to-back `rx_vld` with no gaps is fully supported; no byte is dropped.
- **Next frame:** a new frame may begin on the byte immediately after a commit or abort.
- **`busy`:** combinational from state; high from the cycle after the first `&` until the cycle after commit or abort.
- **Width rule:** the overflow check is exact. With VALUE_W=32, 4294967295 is accepted and 4294967296 is rejected.

## Test plan
1. **Good frame, no gaps.** Drive `&&F:12345&&` back-to-back. Expect:
   - `cmd_vld` for 1 cycle, one cycle after the last `&`.
   - `cmd_key`=8'h46, `cmd_value`=12345, `err_code`=0, `busy` low afterwards.
2. **Boundary values.** Drive `&&A:4294967295&&`, then `&&A:4294967296&&`, then `&&A:00000000001&&` (11 digits). Expect:
   - First frame: `cmd_vld`, value 32'hFFFFFFFF.
   - Second frame: `cmd_err`, `err_code`=2 on the final `6`.
   - Third frame: `cmd_err`, `err_code`=2 on the 11th digit.
   - `cmd_value` stays 32'hFFFFFFFF throughout.
3. **Malformed frames.** Drive `&&f:1&&`, `&&B1&&`, `&&C:&&` and `&&D:12&x`. Expect `cmd_err` with `err_code`=1 for each, at the `f`, `1`, second `&` and `x` bytes respectively, and no `cmd_vld`.
4. **Sync tolerance and noise.** Drive `x&y&&&&G:7&&`. Expect:
   - The leading `&y` returns the FSM to idle with no error.
   - The extra `&&` are tolerated.
   - `cmd_vld` with key `G`, value 7.
5. **Timeout.** Use TIMEOUT_CYCLES=100. Send `&&H:5`, then idle. Expect:
   - `cmd_err` with `err_code`=3 exactly 100 cycles after the `5` byte.
   - A following `&&H:5&&` decodes normally.
   - A byte arriving in the threshold cycle suppresses the timeout.
6. **Reset mid-frame.** Send `&&K:99`, pulse `sys_rst_n` low for 1 cycle, then send `9&&`. Expect:
   - All outputs are 0 after reset.
   - The `9&&` produces no pulse.
   - A subsequent `&&K:1&&` yields value 1.
